// File: rtl/lgate_tester_if.sv
// lgate_tester_if -- bundle of the tester's control/status and gate-bank signals.
//   start      : request a test run (sampled only while idle)
//   y_in[6:0]  : gate-bank response {NOT a, XNOR, NOR, NAND, OR, XOR, AND}
//   a_out/b_out: registered stimulus to the gate bank
//   busy, done : run in progress / one-cycle end-of-run pulse
//   pass, err_mask[6:0], fail_count[2:0] : results of the last run
// master = the tester itself, slave = whoever drives start/y_in and reads results.
interface lgate_tester_if;
    logic       start;
    logic [6:0] y_in;
    logic       a_out;
    logic       b_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [6:0] err_mask;
    logic [2:0] fail_count;

    modport master (
        input  start, y_in,
        output a_out, b_out, busy, done, pass, err_mask, fail_count
    );

    modport slave (
        output start, y_in,
        input  a_out, b_out, busy, done, pass, err_mask, fail_count
    );
endinterface

// File: rtl/lgate_tester.sv
// lgate_tester -- exhaustive two-input logic-gate bank tester.
// Applies the four vectors {a,b} = 00,01,10,11, waits SETTLE cycles after each,
// then compares the 7-bit gate response with the ideal response and accumulates
// an error mask and a count of failing vectors.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : lgate_tester_if.master (start, y_in in; a_out, b_out, busy, done,
//         pass, err_mask, fail_count out -- all outputs registered)
// Parameter SETTLE: wait cycles per vector, legal range 1..15.
module lgate_tester #(
    parameter int unsigned SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    lgate_tester_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    // Ideal gate-bank response for inputs a, b (bit 6..0).
    function automatic logic [6:0] expected_resp(input logic a, input logic b);
        return {~a, ~(a ^ b), ~(a | b), ~(a & b), a | b, a ^ b, a & b};
    endfunction

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [6:0] err_q, err_d;
    logic [2:0] fcnt_q, fcnt_d;
    logic [6:0] diff_s;
    logic [1:0] idx_next_s;

    // Next-state and next-output computation.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        a_d        = a_q;
        b_d        = b_q;
        pass_d     = pass_q;
        err_d      = err_q;
        fcnt_d     = fcnt_q;
        // a_out/b_out are the vector under test, so they give the expected value.
        diff_s     = bus.y_in ^ expected_resp(a_q, b_q);
        idx_next_s = idx_q + 2'd1;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    idx_d   = 2'd0;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    err_d   = 7'd0;
                    fcnt_d  = 3'd0;
                    pass_d  = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_CHECK: begin
                err_d = err_q | diff_s;
                // At most four vectors per run, saturate anyway so it can never wrap.
                if ((diff_s != 7'd0) && (fcnt_q < 3'd4)) begin
                    fcnt_d = fcnt_q + 3'd1;
                end else begin
                    fcnt_d = fcnt_q;
                end
                if (idx_q != 2'd3) begin
                    idx_d   = idx_next_s;
                    a_d     = idx_next_s[1];
                    b_d     = idx_next_s[0];
                    cnt_d   = 4'd0;
                    state_d = ST_SETTLE;
                end else begin
                    // Pass uses the mask including the last vector's contribution.
                    pass_d  = (err_d == 7'd0);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy/done are registered versions of the state being entered.
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 7'd0;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_mask   = err_q;
    assign bus.fail_count = fcnt_q;

endmodule

// File: tb/tb_lgate_tester.sv
// tb_lgate_tester -- self-checking bench for lgate_tester (SETTLE=2).
// A simulated gate bank (with selectable faults) answers the DUT's stimulus.
// A run-timing model predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_lgate_tester;

    localparam int S = 2;
    localparam int L = 4 * (S + 1);

    logic clk;
    logic rst;
    int   mode;
    int   total;
    int   bad;

    lgate_tester_if bus ();

    lgate_tester #(.SETTLE(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ideal gate bank.
    function automatic logic [6:0] good_y(input logic a, input logic b);
        logic [6:0] y;
        y[0] = a & b;
        y[1] = a ^ b;
        y[2] = a | b;
        y[3] = ~(a & b);
        y[4] = ~(a | b);
        y[5] = ~(a ^ b);
        y[6] = ~a;
        return y;
    endfunction

    // Gate bank as presented to the DUT: 0 good, 1 y[1] stuck-0,
    // 2 every output inverted, 3 y[6] wrong only for vector 11.
    function automatic logic [6:0] bank_y(input logic a, input logic b, input int m);
        logic [6:0] y;
        y = good_y(a, b);
        case (m)
            1: y[1] = 1'b0;
            2: y = ~y;
            3: if (a && b) y[6] = ~y[6];
            default: ;
        endcase
        return y;
    endfunction

    function automatic logic [6:0] verr(input logic [1:0] v, input int m);
        return bank_y(v[1], v[0], m) ^ good_y(v[1], v[0]);
    endfunction

    assign bus.y_in = bank_y(bus.a_out, bus.b_out, mode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k = cycles since the accepting edge (-1 idle, L = done cycle).
    int         m_k;
    logic [1:0] m_vec;
    logic [6:0] m_err;
    int         m_fc;
    logic       m_pass;
    logic       m_valid;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_k     <= -1;
            m_vec   <= 2'd0;
            m_err   <= 7'd0;
            m_fc    <= 0;
            m_pass  <= 1'b0;
        end else if (m_k == -1) begin
            if (bus.start) begin
                m_k    <= 0;
                m_vec  <= 2'd0;
                m_err  <= 7'd0;
                m_fc   <= 0;
                m_pass <= 1'b0;
            end
        end else if (m_k == L) begin
            m_k <= -1;
        end else begin
            m_k <= m_k + 1;
            if ((m_k % (S + 1)) == S) begin
                m_err <= m_err | verr(m_vec, mode);
                m_fc  <= m_fc + ((verr(m_vec, mode) != 7'd0) ? 1 : 0);
                if (m_k == L - 1)
                    m_pass <= ((m_err | verr(m_vec, mode)) == 7'd0);
                if (m_vec != 2'd3)
                    m_vec <= m_vec + 2'd1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("a_out",      32'(bus.a_out),      32'(m_vec[1]));
            check("b_out",      32'(bus.b_out),      32'(m_vec[0]));
            check("busy",       32'(bus.busy),       32'((m_k >= 0) && (m_k < L)));
            check("done",       32'(bus.done),       32'(m_k == L));
            check("pass",       32'(bus.pass),       32'(m_pass));
            check("err_mask",   32'(bus.err_mask),   32'(m_err));
            check("fail_count", 32'(bus.fail_count), 32'(m_fc));
        end
    end

    // One full run with a single start pulse; pins latency, sequence and results.
    task automatic run_one(input int m, input logic e_pass, input logic [6:0] e_err,
                           input logic [2:0] e_fc, input string tag);
        int n;
        int busy_cnt;
        logic seen;
        logic [7:0] seq;
        n = 0; busy_cnt = 0; seen = 1'b0; seq = 8'd0;
        @(posedge clk); #2;
        mode = m;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            if ((n % (S + 1)) == 0 && n < L) seq = {seq[5:0], bus.a_out, bus.b_out};
            n++;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_latency"},   32'(n), 32'd12);
        check({tag, "_busy_cyc"},  32'(busy_cnt), 32'd12);
        check({tag, "_vec_seq"},   32'(seq), 32'h1B);
        check({tag, "_pass"},      32'(bus.pass), 32'(e_pass));
        check({tag, "_err"},       32'(bus.err_mask), 32'(e_err));
        check({tag, "_fcnt"},      32'(bus.fail_count), 32'(e_fc));
    endtask

    initial begin
        int n;
        total = 0;
        bad = 0;
        mode = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        @(negedge clk);
        check("rst_a_out", 32'(bus.a_out), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_pass",  32'(bus.pass), 32'd0);
        check("rst_err",   32'(bus.err_mask), 32'd0);
        check("rst_fcnt",  32'(bus.fail_count), 32'd0);

        run_one(0, 1'b1, 7'b0000000, 3'd0, "good");
        run_one(1, 1'b0, 7'b0000010, 3'd2, "stuck_y1");
        run_one(2, 1'b0, 7'b1111111, 3'd4, "invert");
        run_one(3, 1'b0, 7'b1000000, 3'd1, "y6_last");

        // Results hold while idle.
        repeat (3) @(negedge clk);
        check("hold_err",  32'(bus.err_mask), 32'h40);
        check("hold_fcnt", 32'(bus.fail_count), 32'd1);

        // Mid-run start pulses ignored; start held across DONE starts a new run.
        @(posedge clk); #2;
        mode = 2;
        bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2 bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #2 bus.start = 1'b1;
        n = 0;
        while (n < 100 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        check("held_done",    32'(bus.done), 32'd1);
        check("held_err",     32'(bus.err_mask), 32'h7F);
        check("held_fcnt",    32'(bus.fail_count), 32'd4);
        @(negedge clk);
        check("held_idle",    32'(bus.busy), 32'd0);
        check("held_idle_err", 32'(bus.err_mask), 32'h7F);
        @(posedge clk); #2;
        mode = 0;
        bus.start = 1'b0;
        @(negedge clk);
        check("run2_busy", 32'(bus.busy), 32'd1);
        check("run2_err",  32'(bus.err_mask), 32'd0);
        check("run2_fcnt", 32'(bus.fail_count), 32'd0);
        check("run2_pass", 32'(bus.pass), 32'd0);
        n = 0;
        while (n < 100 && !bus.done) begin
            @(negedge clk);
            n++;
        end
        check("run2_pass_end", 32'(bus.pass), 32'd1);

        // Reset during SETTLE of vector 10 aborts the run with no done pulse.
        @(posedge clk); #2;
        bus.start = 1'b1;
        @(posedge clk); #2 bus.start = 1'b0;
        n = 0;
        @(negedge clk);
        while (n < 100 && !(bus.busy && bus.a_out && !bus.b_out)) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached", 32'(bus.a_out && !bus.b_out), 32'd1);
        rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("abort_a",    32'(bus.a_out), 32'd0);
        check("abort_b",    32'(bus.b_out), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_err",  32'(bus.err_mask), 32'd0);
        n = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) n++;
        end
        check("abort_no_done", 32'(n), 32'd0);

        run_one(0, 1'b1, 7'b0000000, 3'd0, "after_rst");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
